// File: rtl/pcie_egress_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_egress_drain_pkg
// Description : Shared constants for the PCIE egress drain: word geometry,
//               field positions and the round-robin port picker.
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_egress_drain_pkg;

    localparam int TAMANO_DATOS = 12;
    localparam int CLASS_MSB    = 11;
    localparam int CLASS_LSB    = 10;
    localparam int DEST_MSB     = 9;
    localparam int DEST_LSB     = 8;
    localparam int NUM_PORTS    = 4;
    localparam int PORT_W       = 2;

    // Returns {found, index}: the first requesting port searching upward from
    // last+1 (mod NUM_PORTS). The loop runs from the farthest candidate to the
    // nearest so that the nearest hit is the one left in the result.
    function automatic logic [PORT_W:0] rr_pick(
        input logic [NUM_PORTS-1:0] req,
        input logic [PORT_W-1:0]    last
    );
        logic [PORT_W:0]   result;
        logic [PORT_W-1:0] idx;
        result = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = last + PORT_W'(k);
            if (req[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_egress_drain_skid.sv
`default_nettype none
// ============================================================================
// Module      : skid_buf2
// Description : Two-entry FIFO holding {port tag, word} pairs between the
//               capture stage and the backpressured output.
//   clk, reset   : clock, synchronous active-high reset
//   i_push       : write i_push_data this cycle (caller guarantees not full)
//   i_pop        : remove head entry this cycle (caller guarantees not empty)
//   o_head       : head entry (zero after reset)
//   o_occupancy  : number of stored entries, 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buf2 #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_occupancy
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Push and pop together leave the occupancy unchanged; the
            // pointers still advance, so ordering is preserved.
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_occupancy = r_occ;

endmodule
`default_nettype wire

// File: rtl/pcie_egress_drain.sv
`default_nettype none
// ============================================================================
// Module      : pcie_egress_drain
// Description : Drains the four PCIE output FIFOs round-robin, captures each
//               popped word one cycle after its pop, and merges the words into
//               a single valid/ready stream through a 2-entry skid buffer.
//               Flags words whose dest field differs from their source port
//               and counts delivered words per port (saturating).
//   clk, reset        : clock, synchronous active-high reset
//   empty[3:0]        : FIFO empty flags, bit i = port i
//   data_in0..3       : FIFO read data, valid one cycle after pop[i]
//   pop[3:0]          : registered one-hot FIFO read enable
//   ready             : downstream accepts data_out this cycle
//   data_out, valid   : head word of the skid buffer and its valid flag
//   port_out          : source port of data_out
//   dest_err          : sticky dest-mismatch flag
//   cnt_idx, cnt_data : combinational read of a per-port delivered counter
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_egress_drain #(
    parameter int TAMANO_DATOS = 12,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              empty,
    input  logic [TAMANO_DATOS-1:0] data_in0,
    input  logic [TAMANO_DATOS-1:0] data_in1,
    input  logic [TAMANO_DATOS-1:0] data_in2,
    input  logic [TAMANO_DATOS-1:0] data_in3,
    output logic [3:0]              pop,
    input  logic                    ready,
    output logic [TAMANO_DATOS-1:0] data_out,
    output logic                    valid,
    output logic [1:0]              port_out,
    output logic                    dest_err,
    input  logic [1:0]              cnt_idx,
    output logic [CNT_WIDTH-1:0]    cnt_data
);

    import pcie_egress_drain_pkg::*;

    localparam int                   c_entry_w = PORT_W + TAMANO_DATOS;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic [NUM_PORTS-1:0]    r_pop;
    logic [PORT_W-1:0]       r_last_grant;
    logic                    r_cap;
    logic [PORT_W-1:0]       r_cap_tag;
    logic                    r_dest_err;
    logic [CNT_WIDTH-1:0]    r_cnt [NUM_PORTS];

    logic [1:0]              w_occ;
    logic [c_entry_w-1:0]    w_head;
    logic                    w_transfer;
    logic [PORT_W:0]         w_pick;
    logic [2:0]              w_pending;
    logic                    w_issue;
    logic [NUM_PORTS-1:0]    w_pop_next;
    logic [TAMANO_DATOS-1:0] w_cap_word;
    logic                    w_dest_bad;

    // Words already committed to the buffer: those stored, the one being
    // captured this cycle (r_cap) and the one whose pop is on the wire now
    // (r_pop). Counting the last two keeps the buffer from ever overflowing
    // regardless of downstream backpressure.
    assign w_pending = {1'b0, w_occ} + {2'b00, r_cap} + {2'b00, |r_pop};
    assign w_pick    = rr_pick(~empty, r_last_grant);
    assign w_issue   = w_pick[PORT_W] && (w_pending < 3'd2);

    always_comb begin
        w_pop_next = '0;
        if (w_issue) begin
            w_pop_next[w_pick[PORT_W-1:0]] = 1'b1;
        end
    end

    always_comb begin
        w_cap_word = data_in0;
        case (r_cap_tag)
            2'd0:    w_cap_word = data_in0;
            2'd1:    w_cap_word = data_in1;
            2'd2:    w_cap_word = data_in2;
            default: w_cap_word = data_in3;
        endcase
    end

    assign w_dest_bad = r_cap && (w_cap_word[DEST_MSB:DEST_LSB] != r_cap_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pop        <= '0;
            r_last_grant <= PORT_W'(NUM_PORTS - 1);
            r_cap        <= 1'b0;
            r_cap_tag    <= '0;
            r_dest_err   <= 1'b0;
        end else begin
            r_pop <= w_pop_next;
            if (w_issue) begin
                r_last_grant <= w_pick[PORT_W-1:0];
            end
            // While r_pop is high, r_last_grant already names its port.
            r_cap     <= |r_pop;
            r_cap_tag <= r_last_grant;
            if (w_dest_bad) begin
                r_dest_err <= 1'b1;
            end
        end
    end

    skid_buf2 #(
        .WIDTH(c_entry_w)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_cap),
        .i_push_data ({r_cap_tag, w_cap_word}),
        .i_pop       (w_transfer),
        .o_head      (w_head),
        .o_occupancy (w_occ)
    );

    assign valid      = (w_occ != 2'd0);
    assign data_out   = w_head[TAMANO_DATOS-1:0];
    assign port_out   = w_head[c_entry_w-1 -: PORT_W];
    assign w_transfer = valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_transfer && (port_out == PORT_W'(i)) && (r_cnt[i] != c_cnt_max)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign pop      = r_pop;
    assign dest_err = r_dest_err;
    assign cnt_data = r_cnt[cnt_idx];

endmodule
`default_nettype wire

// File: tb/tb_pcie_egress_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_egress_drain
// Description : Self-checking bench for pcie_egress_drain. Emulates the four
//               upstream FIFOs with queues and checks the output stream,
//               counters and dest flag against a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_egress_drain;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   empty;
    logic [W-1:0] din [4];
    logic [3:0]   pop;
    logic         ready;
    logic [W-1:0] data_out;
    logic         valid;
    logic [1:0]   port_out;
    logic         dest_err;
    logic [1:0]   cnt_idx;
    logic [7:0]   cnt_data;

    always #5 clk = ~clk;

    pcie_egress_drain #(
        .TAMANO_DATOS(12),
        .CNT_WIDTH   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .empty    (empty),
        .data_in0 (din[0]),
        .data_in1 (din[1]),
        .data_in2 (din[2]),
        .data_in3 (din[3]),
        .pop      (pop),
        .ready    (ready),
        .data_out (data_out),
        .valid    (valid),
        .port_out (port_out),
        .dest_err (dest_err),
        .cnt_idx  (cnt_idx),
        .cnt_data (cnt_data)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [W-1:0] fifo_q [4][$];
    logic [13:0]  sb [$];
    int           m_cnt [4];
    int           pop_log [$];
    int           err_at   = 1 << 30;
    logic         stage_vld = 1'b0;
    int           stage_p   = 0;
    logic [W-1:0] stage_w   = '0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic [1:0]   prev_port = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] make_word(input int p, input bit bad);
        logic [1:0] d;
        d = bad ? 2'(p + 1) : 2'(p);
        return {2'($urandom), d, 8'($urandom)};
    endfunction

    task automatic push_word(input int p, input logic [W-1:0] w);
        fifo_q[p].push_back(w);
        empty[p] = 1'b0;
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (sb.size() == 0);
        for (int i = 0; i < 4; i++) begin
            if (fifo_q[i].size() != 0) idle = 1'b0;
        end
        return idle;
    endfunction

    // One clock: output-side checks before the edge, upstream FIFO emulation
    // and reference updates just after it.
    task automatic tick();
        logic        was_reset;
        logic [13:0] exp;
        logic [W-1:0] w;
        int          p;
        if (!reset) begin
            if (prev_hold) begin
                check_eq("hold_valid", valid, 1);
                check_eq("hold_data", data_out, prev_data);
                check_eq("hold_port", port_out, prev_port);
            end
            if (valid && ready) begin
                check_eq("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check_eq("out_data", data_out, exp[11:0]);
                    check_eq("out_port", port_out, exp[13:12]);
                    if (m_cnt[exp[13:12]] < 255) m_cnt[exp[13:12]]++;
                end
            end
            prev_hold = valid && !ready;
            prev_data = data_out;
            prev_port = port_out;
        end
        was_reset = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (stage_vld) begin
            din[stage_p] = stage_w;
            stage_vld = 1'b0;
        end
        if (was_reset) begin
            sb.delete();
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            err_at = 1 << 30;
            prev_hold = 1'b0;
            check_eq("pop_after_reset", pop, 0);
        end else begin
            check_eq("pop_onehot", $countones(pop) <= 1, 1);
            if (pop != 4'b0) begin
                p = 0;
                for (int i = 0; i < 4; i++) if (pop[i]) p = i;
                pop_log.push_back(p);
                check_eq("pop_nonempty", fifo_q[p].size() != 0, 1);
                if (fifo_q[p].size() != 0) begin
                    w = fifo_q[p].pop_front();
                    sb.push_back({2'(p), w});
                    stage_vld = 1'b1;
                    stage_p   = p;
                    stage_w   = w;
                    if (w[9:8] != 2'(p) && err_at > cyc + 2) err_at = cyc + 2;
                    if (fifo_q[p].size() == 0) empty[p] = 1'b1;
                end
            end
        end
        check_eq("dest_err", dest_err, cyc >= err_at);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        for (int i = 0; i < 4; i++) begin
            cnt_idx = 2'(i);
            #1;
            check_eq(tag, cnt_data, m_cnt[i]);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        ready = 1'b1;
        while (!all_idle() && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, all_idle(), 1);
    endtask

    initial begin
        int pop_cyc;
        int val_cyc;
        int npop;
        int p;
        logic [W-1:0] b_data;
        logic [1:0]   b_port;

        reset   = 1'b1;
        empty   = 4'hF;
        ready   = 1'b0;
        cnt_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            din[i]   = '0;
            m_cnt[i] = 0;
        end

        // Reset then idle
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("idle_pop", pop, 0);
            check_eq("idle_valid", valid, 0);
        end
        check_eq("idle_data", data_out, 0);
        check_eq("idle_port", port_out, 0);
        check_counters("idle_cnt");

        // Single word from port 2
        push_word(2, 12'h2A5);
        ready   = 1'b1;
        pop_cyc = -1;
        val_cyc = -1;
        npop    = 0;
        b_data  = '0;
        b_port  = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (pop != 4'b0) begin
                npop++;
                pop_cyc = cyc;
                check_eq("single_pop", pop, 4'b0100);
            end
            if (valid && val_cyc < 0) begin
                val_cyc = cyc;
                b_data  = data_out;
                b_port  = port_out;
            end
        end
        check_eq("single_npop", npop, 1);
        check_eq("single_latency", val_cyc - pop_cyc, 2);
        check_eq("single_data", b_data, 12'h2A5);
        check_eq("single_port", b_port, 2);
        cnt_idx = 2'd2;
        #1;
        check_eq("single_cnt2", cnt_data, 1);

        // Round-robin with three words per port
        do_reset();
        pop_log.delete();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++) push_word(i, make_word(i, 1'b0));
        drain("rr_drain", 300);
        check_eq("rr_npops", pop_log.size(), 12);
        for (int i = 0; i < pop_log.size() && i < 12; i++) check_eq("rr_order", pop_log[i], i % 4);
        check_counters("rr_cnt");
        cnt_idx = 2'd3;
        #1;
        check_eq("rr_cnt3", cnt_data, 3);

        // Backpressure: exactly two pops while ready is low
        ready = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++) push_word(i, make_word(i, 1'b0));
        npop = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (pop != 4'b0) npop++;
        end
        check_eq("bp_npops", npop, 2);
        check_eq("bp_valid", valid, 1);
        drain("bp_drain", 400);
        check_counters("bp_cnt");

        // Dest mismatch on port 1
        push_word(1, 12'h0C3);
        drain("derr_drain", 50);
        check_eq("derr_sticky", dest_err, 1);
        check_counters("derr_cnt");

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                p = $urandom_range(0, 3);
                if (fifo_q[p].size() < 6) push_word(p, make_word(p, $urandom_range(0, 19) == 0));
            end
            tick();
        end
        drain("rand_drain", 2000);
        check_counters("rand_cnt");

        // Saturation, then reset with a pop in flight
        do_reset();
        for (int i = 0; i < 260; i++) push_word(0, (i == 100) ? 12'h155 : {4'b0000, 8'(i)});
        drain("sat_drain", 3000);
        cnt_idx = 2'd0;
        #1;
        check_eq("sat_cnt0", cnt_data, 255);
        check_eq("sat_err", dest_err, 1);
        ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(0, make_word(0, 1'b0));
        for (int k = 0; k < 20 && !valid; k++) tick();
        check_eq("rst_valid_before", valid, 1);
        do_reset();
        check_eq("rst_valid", valid, 0);
        check_eq("rst_err", dest_err, 0);
        check_counters("rst_cnt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
